// File: rtl/alu_shifter_seq.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shifter that advances SHIFT_STEP bit positions per cycle.
module alu_shifter_seq #(
   parameter int WIDTH      = 16,
   parameter int SHIFT_STEP = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               op,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic [$clog2(WIDTH)-1:0] shift_d,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         res,
   output logic [3:0]               szcv,
   output logic                     err
);

   localparam int                 SHAMT_W   = $clog2(WIDTH);
   localparam logic [SHAMT_W:0]   STEP_EXT  = (SHAMT_W+1)'(SHIFT_STEP);
   localparam logic [SHAMT_W-1:0] STEP_AMT  = STEP_EXT[SHAMT_W-1:0];
   localparam logic [SHAMT_W:0]   WIDTH_EXT = (SHAMT_W+1)'(WIDTH);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b0101;
   localparam logic [3:0] OP_MOV = 4'b0110;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SLR = 2'b01;
   localparam logic [1:0] SH_SRL = 2'b10;
   localparam logic [1:0] SH_SRA = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [3:0]         szcv_q, szcv_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [1:0]         kind_q, kind_d;

   logic               accept_s;
   logic [WIDTH-1:0]   sh_val_s;
   logic [SHAMT_W-1:0] sh_rem_s;
   logic [1:0]         sh_kind_s;
   logic [SHAMT_W-1:0] sh_amt_s;
   logic               sh_last_s;
   logic [WIDTH:0]     sh_out_s;
   logic               sh_cfin_s;
   logic [WIDTH+4:0]   alu_out_s;

   // One shifter step by amt bits; returns {last bit shifted out, result}.
   function automatic logic [WIDTH:0] shift_step(input logic [1:0]         kind,
                                                 input logic [WIDTH-1:0]   val,
                                                 input logic [SHAMT_W-1:0] amt);
      logic [WIDTH:0]   ext;
      logic [SHAMT_W:0] back;
      logic [WIDTH:0]   r;
      ext  = '0;
      back = '0;
      r    = '0;
      case (kind)
         SH_SLL: begin
            ext = {1'b0, val} << amt;
            r   = ext;
         end
         SH_SLR: begin
            back = WIDTH_EXT - {1'b0, amt};
            r    = {1'b0, (val << amt) | (val >> back)};
         end
         SH_SRL: begin
            ext = {val, 1'b0} >> amt;
            r   = {ext[0], ext[WIDTH:1]};
         end
         SH_SRA: begin
            ext = $signed({val, 1'b0}) >>> amt;
            r   = {ext[0], ext[WIDTH:1]};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Single-cycle ops; returns {err, S, Z, C, V, res}.
   function automatic logic [WIDTH+4:0] alu_eval(input logic [3:0]       opc,
                                                 input logic [WIDTH-1:0] av,
                                                 input logic [WIDTH-1:0] bv);
      logic [WIDTH:0]   wide;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] fl;
      logic             c;
      logic             v;
      logic             e;
      wide = '0;
      r    = '0;
      c    = 1'b0;
      v    = 1'b0;
      e    = 1'b0;
      case (opc)
         OP_ADD: begin
            wide = {1'b0, bv} + {1'b0, av};
            r    = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            v    = (av[WIDTH-1] == bv[WIDTH-1]) && (r[WIDTH-1] != bv[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            wide = {1'b0, bv} - {1'b0, av};
            r    = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            v    = (av[WIDTH-1] != bv[WIDTH-1]) && (r[WIDTH-1] != bv[WIDTH-1]);
         end
         OP_AND:  r = av & bv;
         OP_OR:   r = av | bv;
         OP_XOR:  r = av ^ bv;
         OP_MOV:  r = av;
         default: e = 1'b1;
      endcase
      // CMP reports b but flags the difference
      fl = r;
      r  = (opc == OP_CMP) ? bv : fl;
      if (e) begin
         return {1'b1, 4'b0000, {WIDTH{1'b0}}};
      end else begin
         return {1'b0, fl[WIDTH-1], (fl == {WIDTH{1'b0}}), c, v, r};
      end
   endfunction

   assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign out_valid = out_valid_q;
   assign res       = res_q;
   assign szcv      = szcv_q;
   assign err       = err_q;

   // Shifter operand select: fresh operands on accept, working register while shifting.
   always_comb begin
      if (state_q == ST_SHIFT) begin
         sh_val_s  = work_q;
         sh_rem_s  = rem_q;
         sh_kind_s = kind_q;
      end else begin
         sh_val_s  = b;
         sh_rem_s  = shift_d;
         sh_kind_s = op[1:0];
      end
      if ({1'b0, sh_rem_s} > STEP_EXT) begin
         sh_amt_s  = STEP_AMT;
         sh_last_s = 1'b0;
      end else begin
         sh_amt_s  = sh_rem_s;
         sh_last_s = 1'b1;
      end
      sh_out_s  = shift_step(sh_kind_s, sh_val_s, sh_amt_s);
      sh_cfin_s = (sh_kind_s == SH_SLR) ? (sh_out_s[0] && (sh_amt_s != '0)) : sh_out_s[WIDTH];
      alu_out_s = alu_eval(op, a, b);
   end

   // Next-state logic for the FSM, shift engine and result registers.
   always_comb begin
      accept_s    = in_valid && in_ready;
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      res_d       = res_q;
      szcv_d      = szcv_q;
      err_d       = err_q;
      work_d      = work_q;
      rem_d       = rem_q;
      kind_d      = kind_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && (op[3:2] == 2'b10)) begin
               if (sh_last_s) begin
                  out_valid_d = 1'b1;
                  res_d       = sh_out_s[WIDTH-1:0];
                  szcv_d      = {sh_out_s[WIDTH-1], (sh_out_s[WIDTH-1:0] == '0), sh_cfin_s, 1'b0};
                  err_d       = 1'b0;
               end else begin
                  work_d      = sh_out_s[WIDTH-1:0];
                  rem_d       = sh_rem_s - sh_amt_s;
                  kind_d      = op[1:0];
                  out_valid_d = 1'b0;
                  state_d     = ST_SHIFT;
               end
            end else if (accept_s) begin
               out_valid_d = 1'b1;
               err_d       = alu_out_s[WIDTH+4];
               szcv_d      = alu_out_s[WIDTH+3:WIDTH];
               res_d       = alu_out_s[WIDTH-1:0];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            work_d = sh_out_s[WIDTH-1:0];
            rem_d  = sh_rem_s - sh_amt_s;
            if (sh_last_s) begin
               out_valid_d = 1'b1;
               res_d       = sh_out_s[WIDTH-1:0];
               szcv_d      = {sh_out_s[WIDTH-1], (sh_out_s[WIDTH-1:0] == '0), sh_cfin_s, 1'b0};
               err_d       = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers; asynchronous clear abandons any shift in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         szcv_q      <= 4'b0000;
         err_q       <= 1'b0;
         work_q      <= '0;
         rem_q       <= '0;
         kind_q      <= 2'b00;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         szcv_q      <= szcv_d;
         err_q       <= err_d;
         work_q      <= work_d;
         rem_q       <= rem_d;
         kind_q      <= kind_d;
      end
   end

endmodule

// File: tb/tb_alu_shifter_seq.sv
// Bench for alu_shifter_seq: directed cases plus random ops against an
// arithmetic reference model, for SHIFT_STEP=1 and SHIFT_STEP=4 instances.
module tb_alu_shifter_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_valid4;
   logic        in_ready1, in_ready4;
   logic [3:0]  op;
   logic [15:0] a, b;
   logic [3:0]  shift_d;
   logic        out_ready;
   logic        out_valid1, out_valid4;
   logic [15:0] res1, res4;
   logic [3:0]  szcv1, szcv4;
   logic        err1, err4;
   logic        sel;
   logic        ir_m, ov_m, err_m;
   logic [15:0] res_m;
   logic [3:0]  szcv_m;

   int errors = 0;
   int checks = 0;

   alu_shifter_seq #(.WIDTH(16), .SHIFT_STEP(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .op(op), .a(a), .b(b), .shift_d(shift_d),
      .out_valid(out_valid1), .out_ready(out_ready),
      .res(res1), .szcv(szcv1), .err(err1)
   );

   alu_shifter_seq #(.WIDTH(16), .SHIFT_STEP(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .op(op), .a(a), .b(b), .shift_d(shift_d),
      .out_valid(out_valid4), .out_ready(out_ready),
      .res(res4), .szcv(szcv4), .err(err4)
   );

   assign ir_m   = sel ? in_ready4  : in_ready1;
   assign ov_m   = sel ? out_valid4 : out_valid1;
   assign res_m  = sel ? res4       : res1;
   assign szcv_m = sel ? szcv4      : szcv1;
   assign err_m  = sel ? err4       : err1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: {err, S, Z, C, V, res} from plain integer arithmetic.
   function automatic logic [20:0] model(input logic [3:0] o, input logic [15:0] av,
                                         input logic [15:0] bv, input int d);
      int ua, ub, sa, sb, t;
      logic [31:0] tv;
      logic [15:0] r, fl;
      logic c, v;
      ua = int'(av); ub = int'(bv);
      sa = int'($signed(av)); sb = int'($signed(bv));
      c = 1'b0; v = 1'b0; r = 16'h0000; tv = 32'h0;
      case (o)
         4'd0: begin
            t = ub + ua; tv = t; r = tv[15:0];
            c = (t > 65535);
            v = ((sb + sa) > 32767) || ((sb + sa) < -32768);
         end
         4'd1, 4'd5: begin
            t = ub - ua; tv = t; r = tv[15:0];
            c = (ub < ua);
            v = ((sb - sa) > 32767) || ((sb - sa) < -32768);
         end
         4'd2: r = av & bv;
         4'd3: r = av | bv;
         4'd4: r = av ^ bv;
         4'd6: r = av;
         4'd8: begin
            tv = ub << d; r = tv[15:0];
            if (d != 0) c = ((ub >> (16 - d)) & 1) != 0;
         end
         4'd9: begin
            tv = (ub << d) | (ub >> (16 - d)); r = tv[15:0];
            if (d != 0) c = r[0];
         end
         4'd10: begin
            tv = ub >> d; r = tv[15:0];
            if (d != 0) c = ((ub >> (d - 1)) & 1) != 0;
         end
         4'd11: begin
            tv = sb >>> d; r = tv[15:0];
            if (d != 0) c = ((sb >>> (d - 1)) & 1) != 0;
         end
         default: return {1'b1, 20'h00000};
      endcase
      fl = r;
      if (o == 4'd5) r = bv;
      return {1'b0, fl[15], (fl == 16'h0000), c, v, r};
   endfunction

   function automatic int model_lat(input logic [3:0] o, input int d, input int step);
      if (o >= 4'd8 && o <= 4'd11 && d > 0) return (d + step - 1) / step;
      return 1;
   endfunction

   task automatic do_op(input logic s, input logic [3:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input int d, input logic [20:0] exp,
                        input int lat, input string name);
      int cyc;
      sel = s;
      @(negedge clk);
      checks++;
      if (ir_m !== 1'b1) begin
         errors++; $display("FAIL %s in_ready: got %b want 1", name, ir_m);
      end
      op = o; a = av; b = bv; shift_d = 4'(d);
      if (s) in_valid4 = 1'b1; else in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid4 = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk); cyc++;
      end while (ov_m !== 1'b1 && cyc < 40);
      checks++;
      if (ov_m !== 1'b1 || cyc != lat) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
      end
      checks++;
      if ({err_m, szcv_m, res_m} !== exp) begin
         errors++;
         $display("FAIL %s result: got err=%b szcv=%b res=%h want err=%b szcv=%b res=%h",
                  name, err_m, szcv_m, res_m, exp[20], exp[19:16], exp[15:0]);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; sel = 1'b0;
      op = 4'h0; a = 16'h0; b = 16'h0; shift_d = 4'h0;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0 || res1 !== 16'h0 || szcv1 !== 4'h0 || err1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got rdy=%b ov=%b res=%h szcv=%b err=%b want 0 0 0000 0000 0",
                  in_ready1, out_valid1, res1, szcv1, err1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
         errors++; $display("FAIL reset_idle: got rdy=%b ov=%b want 1 0", in_ready1, out_valid1);
      end
   endtask

   task automatic test_directed;
      do_op(1'b0, 4'b0000, 16'h0001, 16'h7FFF, 0, {1'b0, 4'b1001, 16'h8000}, 1, "add_ovf");
      do_op(1'b0, 4'b0001, 16'h0005, 16'h0003, 0, {1'b0, 4'b1010, 16'hFFFE}, 1, "sub_borrow");
      do_op(1'b0, 4'b0101, 16'h0005, 16'h0005, 0, {1'b0, 4'b0100, 16'h0005}, 1, "cmp_eq");
      do_op(1'b0, 4'b1011, 16'h0000, 16'h8001, 3, {1'b0, 4'b1000, 16'hF000}, 3, "sra_d3");
      do_op(1'b0, 4'b1000, 16'h0000, 16'h1234, 0, {1'b0, 4'b0000, 16'h1234}, 1, "sll_d0");
      do_op(1'b0, 4'b1001, 16'h0000, 16'h8001, 4, {1'b0, 4'b0000, 16'h0018}, 4, "slr_d4");
      do_op(1'b0, 4'b1000, 16'h0000, 16'hC001, 1, {1'b0, 4'b1010, 16'h8002}, 1, "sll_d1_carry");
      do_op(1'b0, 4'b1001, 16'h0000, 16'h0001, 15, {1'b0, 4'b1000, 16'h8000}, 15, "slr_d15");
   endtask

   task automatic test_random;
      logic [31:0] ra, rb;
      logic [3:0]  o;
      int          d;
      for (int i = 0; i < 150; i++) begin
         ra = $urandom; rb = $urandom;
         o = 4'($urandom_range(0, 15));
         d = $urandom_range(0, 15);
         do_op(1'b0, o, ra[15:0], rb[15:0], d, model(o, ra[15:0], rb[15:0], d),
               model_lat(o, d, 1), "random");
      end
   endtask

   task automatic test_back_to_back;
      logic [20:0] exp_q[$];
      logic [20:0] exp;
      logic [31:0] ra, rb;
      logic [3:0]  o;
      sel = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i <= 10; i++) begin
         if (i > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (out_valid1 !== 1'b1 || {err1, szcv1, res1} !== exp) begin
               errors++;
               $display("FAIL b2b_%0d: got ov=%b err=%b szcv=%b res=%h want ov=1 err=%b szcv=%b res=%h",
                        i, out_valid1, err1, szcv1, res1, exp[20], exp[19:16], exp[15:0]);
            end
         end
         if (i < 10) begin
            checks++;
            if (in_ready1 !== 1'b1) begin
               errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready1);
            end
            ra = $urandom; rb = $urandom;
            o = 4'($urandom_range(0, 6));
            op = o; a = ra[15:0]; b = rb[15:0]; shift_d = 4'h0; in_valid = 1'b1;
            exp_q.push_back(model(o, ra[15:0], rb[15:0], 0));
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid1 !== 1'b0) begin
         errors++; $display("FAIL b2b_drain: got ov=%b want 0", out_valid1);
      end
   endtask

   task automatic test_backpressure;
      sel = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      op = 4'b0000; a = 16'h1111; b = 16'h2222; shift_d = 4'h0; in_valid = 1'b1;
      @(posedge clk); #1;
      op = 4'b0110; a = 16'hABCD; b = 16'h0F0F;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid1 !== 1'b1 || res1 !== 16'h3333 || szcv1 !== 4'b0000 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: got ov=%b res=%h szcv=%b rdy=%b want 1 3333 0000 0",
                     i, out_valid1, res1, szcv1, in_ready1);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready1 !== 1'b1) begin
         errors++; $display("FAIL release_ready: got %b want 1", in_ready1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid1 !== 1'b1 || {err1, szcv1, res1} !== {1'b0, 4'b1000, 16'hABCD}) begin
         errors++;
         $display("FAIL same_edge: got ov=%b err=%b szcv=%b res=%h want 1 0 1000 abcd",
                  out_valid1, err1, szcv1, res1);
      end
      @(negedge clk);
      checks++;
      if (out_valid1 !== 1'b0) begin
         errors++; $display("FAIL post_drain: got ov=%b want 0", out_valid1);
      end
   endtask

   task automatic test_shift_busy;
      logic [31:0] rb;
      logic [20:0] exp;
      int cyc;
      sel = 1'b0;
      rb = $urandom;
      exp = model(4'b1010, 16'h0000, rb[15:0], 8);
      @(negedge clk);
      op = 4'b1010; a = 16'h0000; b = rb[15:0]; shift_d = 4'd8; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk); cyc++;
         if (cyc == 2) begin
            checks++;
            if (in_ready1 !== 1'b0) begin
               errors++; $display("FAIL busy_ready: got %b want 0", in_ready1);
            end
            op = 4'b0000; a = 16'h1234; b = 16'h4321; shift_d = 4'd0; in_valid = 1'b1;
         end else if (cyc == 4) begin
            in_valid = 1'b0;
         end
      end while (out_valid1 !== 1'b1 && cyc < 40);
      in_valid = 1'b0;
      checks++;
      if (cyc != 8 || {err1, szcv1, res1} !== exp) begin
         errors++;
         $display("FAIL busy_srl: got lat=%0d szcv=%b res=%h want lat=8 szcv=%b res=%h",
                  cyc, szcv1, res1, exp[19:16], exp[15:0]);
      end
      @(negedge clk);
      checks++;
      if (out_valid1 !== 1'b0) begin
         errors++; $display("FAIL busy_ignored: got ov=%b want 0", out_valid1);
      end
   endtask

   task automatic test_reset_mid_shift;
      logic        stray;
      logic [31:0] ra;
      do_op(1'b0, 4'b0110, 16'h5A5A, 16'h0000, 0, {1'b0, 4'b0000, 16'h5A5A}, 1, "mov_pre");
      @(negedge clk);
      op = 4'b1000; a = 16'h0000; b = 16'h00FF; shift_d = 4'd10; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid1 !== 1'b0 || res1 !== 16'h0 || szcv1 !== 4'h0 || err1 !== 1'b0 || in_ready1 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got ov=%b res=%h szcv=%b err=%b rdy=%b want all 0",
                  out_valid1, res1, szcv1, err1, in_ready1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stray = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid1 !== 1'b0) stray = 1'b1;
      end
      checks++;
      if (stray !== 1'b0 || in_ready1 !== 1'b1) begin
         errors++; $display("FAIL after_reset: got stray=%b rdy=%b want 0 1", stray, in_ready1);
      end
      ra = $urandom;
      do_op(1'b0, 4'b0111, ra[15:0], ra[31:16], 0, {1'b1, 4'b0000, 16'h0000}, 1, "illegal_0111");
   endtask

   task automatic test_step4;
      logic [31:0] ra, rb;
      logic [3:0]  o;
      int          d;
      do_op(1'b1, 4'b1001, 16'h0000, 16'h8001, 4, {1'b0, 4'b0000, 16'h0018}, 1, "s4_slr_d4");
      do_op(1'b1, 4'b1011, 16'h0000, 16'h8001, 3, {1'b0, 4'b1000, 16'hF000}, 1, "s4_sra_d3");
      for (int i = 0; i < 60; i++) begin
         ra = $urandom; rb = $urandom;
         o = 4'($urandom_range(8, 11));
         d = $urandom_range(0, 15);
         do_op(1'b1, o, ra[15:0], rb[15:0], d, model(o, ra[15:0], rb[15:0], d),
               model_lat(o, d, 4), "s4_random");
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_shift_busy();
      test_reset_mid_shift();
      test_step4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
